// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and constants for the sequential divider
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int ITERS = 8;
  localparam logic [7:0] DIV0_Q = 8'hFF;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a requester and the divider
interface seq_divider_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  logic busy, div_done, div_by_zero, overflow;
  modport master(output start, dividend, divisor,
                 input quotient, remainder, busy, div_done, div_by_zero, overflow);
  modport slave(input start, dividend, divisor,
                output quotient, remainder, busy, div_done, div_by_zero, overflow);
endinterface

// File: rtl/div_fsm.sv
// div_fsm: divider controller producing state, iteration count and datapath enables
module div_fsm import seq_divider_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic divisor_zero,
  output logic busy,
  output logic done,
  output logic load,
  output logic load_zero,
  output logic calc_en,
  output logic fix_en
);
  localparam int CW = $clog2(ITERS);
  state_t state, next;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= load ? '0 : calc_en ? cnt + 1'b1 : cnt;
    end
  always_comb begin
    next      = state;
    load      = 1'b0;
    load_zero = 1'b0;
    calc_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      IDLE: begin
        load      = start && !divisor_zero;
        load_zero = start && divisor_zero;
        next      = load ? CALC : load_zero ? DONE : IDLE;
      end
      CALC: begin
        calc_en = 1'b1;
        next    = (cnt == CW'(ITERS - 1)) ? FIX : CALC;
      end
      FIX: begin
        fix_en = 1'b1;
        next   = DONE;
      end
      default: next = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: signed truncating divider using an 8-step restoring unsigned core
module seq_divider import seq_divider_pkg::*; #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset_n,
  seq_divider_if.slave bus
);
  logic [WIDTH:0] r, d, r_sh, a_dividend, a_divisor;
  logic [WIDTH-1:0] q;
  logic sign_q, sign_r, ge, load, load_zero, calc_en, fix_en;
  // magnitudes kept one bit wider so |-128| stays 128
  assign a_dividend = bus.dividend[WIDTH-1] ? -{1'b1, bus.dividend} : {1'b0, bus.dividend};
  assign a_divisor  = bus.divisor[WIDTH-1]  ? -{1'b1, bus.divisor}  : {1'b0, bus.divisor};
  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign ge   = r_sh >= d;
  div_fsm u_fsm (
    .clk,
    .reset_n,
    .start(bus.start),
    .divisor_zero(bus.divisor == '0),
    .busy(bus.busy),
    .done(bus.div_done),
    .load,
    .load_zero,
    .calc_en,
    .fix_en
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r               <= '0;
      d               <= '0;
      q               <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      if (load) begin
        d               <= a_divisor;
        q               <= a_dividend[WIDTH-1:0];
        r               <= '0;
        sign_q          <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        sign_r          <= bus.dividend[WIDTH-1];
        bus.div_by_zero <= 1'b0;
        bus.overflow    <= 1'b0;
      end
      if (load_zero) begin
        bus.quotient    <= WIDTH'(DIV0_Q);
        bus.remainder   <= bus.dividend;
        bus.div_by_zero <= 1'b1;
        bus.overflow    <= 1'b0;
      end
      if (calc_en) begin
        r <= ge ? r_sh - d : r_sh;
        q <= {q[WIDTH-2:0], ge};
      end
      // a positive quotient of 128 only arises from -128 / -1
      if (fix_en) begin
        bus.quotient  <= sign_q ? -q : q;
        bus.remainder <= sign_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        bus.overflow  <= ~sign_q & q[WIDTH-1];
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an integer-arithmetic model
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  seq_divider_if bus ();
  seq_divider dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] eq, output logic [7:0] er,
                                output logic ez, output logic eo);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      eq = 8'hFF; er = a; ez = 1'b1; eo = 1'b0;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      eq = iq[7:0]; er = ir[7:0]; ez = 1'b0; eo = iq > 127;
    end
  endfunction

  // called one time unit after a rising edge; poke>0 injects a stray 50/5 start at that cycle
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag, input int poke);
    logic [7:0] eq, er;
    logic ez, eo;
    int n;
    model(a, b, eq, er, ez, eo);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
    n = 1;
    while (!bus.div_done && n < 20) begin
      if (n == poke) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk({tag, "_lat"}, n, ez ? 1 : 10);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, ez);
    chk({tag, "_ovf"}, bus.overflow, eo);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {bus.div_done, bus.busy}, 2'b00);
    chk({tag, "_hold"}, {bus.quotient, bus.remainder}, {eq, er});
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1;
    chk("reset_outs", {bus.quotient, bus.remainder, bus.busy, bus.div_done, bus.div_by_zero, bus.overflow}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'd100, 8'd7, "p100_p7", 0);
    run_op(8'h9C, 8'd7, "n100_p7", 0);
    run_op(8'd100, 8'hF9, "p100_n7", 0);
    run_op(8'h9C, 8'hF9, "n100_n7", 0);
    run_op(8'h80, 8'hFF, "n128_n1", 0);
    run_op(8'h80, 8'h01, "n128_p1", 0);
    run_op(8'd5, 8'd0, "p5_zero", 0);
    run_op(8'd9, 8'd3, "p9_p3", 0);
    run_op(8'h80, 8'h80, "n128_n128", 0);
    run_op(8'h7F, 8'h80, "p127_n128", 0);
    run_op(8'h80, 8'h00, "n128_zero", 0);
    run_op(8'd100, 8'd7, "ignore_start", 4);
    // abort mid-calculation with reset
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outs", {bus.quotient, bus.remainder, bus.busy, bus.div_done, bus.div_by_zero, bus.overflow}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    begin
      logic seen = 1'b0;
      repeat (12) begin
        @(posedge clk); #1;
        seen |= bus.div_done;
      end
      chk("abort_no_done", seen, 1'b0);
    end
    run_op(8'd50, 8'd5, "restart_50_5", 0);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i % 10 == 0) ? 8'h00 : 8'($urandom);
      run_op(a, b, $sformatf("rnd_%02h_%02h", a, b), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
